// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left and parallel load.
// A per-direction shift counter strobes word_done after every WIDTH consecutive shifts.
module universal_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] pout,
   output logic             sout_r,
   output logic             sout_l,
   output logic             word_done
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHR   = 2'b01,
      MODE_SHL   = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_R = 1'b0,
      DIR_L = 1'b1
   } dir_t;

   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   dir_t             last_dir, last_dir_nxt;
   logic             done_nxt;
   logic             shift;
   dir_t             dir;
   mode_t            mode_q;

   assign mode_q = mode_t'(mode);

   always_comb begin
      shreg_nxt    = shreg;
      cnt_nxt      = cnt;
      last_dir_nxt = last_dir;
      done_nxt     = 1'b0;
      shift        = 1'b0;
      dir          = DIR_R;

      if (en) begin
         case (mode_q)
            MODE_SHR: begin
               shreg_nxt = {sin_r, shreg[WIDTH-1:1]};
               shift     = 1'b1;
               dir       = DIR_R;
            end
            MODE_SHL: begin
               shreg_nxt = {shreg[WIDTH-2:0], sin_l};
               shift     = 1'b1;
               dir       = DIR_L;
            end
            MODE_LOAD: begin
               shreg_nxt = pin;
               cnt_nxt   = '0;
            end
            default: ;
         endcase
      end

      // A direction change starts a fresh word with this shift as its first bit.
      if (shift) begin
         if (dir != last_dir) begin
            cnt_nxt      = CW'(1);
            last_dir_nxt = dir;
         end else if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            done_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg     <= RST_VAL;
         cnt       <= '0;
         last_dir  <= DIR_R;
         word_done <= 1'b0;
      end else begin
         shreg     <= shreg_nxt;
         cnt       <= cnt_nxt;
         last_dir  <= last_dir_nxt;
         word_done <= done_nxt;
      end
   end

   assign pout   = shreg;
   assign sout_r = shreg[0];
   assign sout_l = shreg[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg: a 4-bit instance (RST_VAL=1010) and an 8-bit one.
module tb_universal_shift_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       en4 = 1'b0, sin_r4 = 1'b0, sin_l4 = 1'b0;
   logic [1:0] mode4 = 2'b00;
   logic [3:0] pin4 = '0, pout4;
   logic       sout_r4, sout_l4, wd4;

   logic       en8 = 1'b0, sin_r8 = 1'b0, sin_l8 = 1'b0;
   logic [1:0] mode8 = 2'b00;
   logic [7:0] pin8 = '0, pout8;
   logic       sout_r8, sout_l8, wd8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   universal_shift_reg #(.WIDTH(4), .RST_VAL(4'b1010)) u_usr4 (
      .clk(clk), .rst(rst), .en(en4), .mode(mode4), .sin_r(sin_r4), .sin_l(sin_l4),
      .pin(pin4), .pout(pout4), .sout_r(sout_r4), .sout_l(sout_l4), .word_done(wd4)
   );

   universal_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_usr8 (
      .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sin_r(sin_r8), .sin_l(sin_l8),
      .pin(pin8), .pout(pout8), .sout_r(sout_r8), .sout_l(sout_l8), .word_done(wd8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc4(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [3:0] p);
      @(negedge clk);
      en4 = e; mode4 = m; sin_r4 = sr; sin_l4 = sl; pin4 = p;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc8(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [7:0] p);
      @(negedge clk);
      en8 = e; mode8 = m; sin_r8 = sr; sin_l8 = sl; pin8 = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] s2;
      logic [3:0] p2 [4];
      logic [7:0] a5, s4, s6;
      s2 = 4'b1101;
      p2[0] = 4'b1101; p2[1] = 4'b0110; p2[2] = 4'b1011; p2[3] = 4'b1101;
      a5 = 8'hA5; s4 = 8'h3C; s6 = 8'h96;

      // 1: reset values, then asynchronous reset in the middle of a shift sequence
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pout4", 32'(pout4), 32'hA);
      chk("rst_wd4", 32'(wd4), 32'h0);
      chk("rst_pout8", 32'(pout8), 32'h00);
      @(negedge clk);
      rst = 1'b1;
      cyc4(1'b1, 2'b01, 1'b0, 1'b1, 4'h0);
      chk("mid_sh1", 32'(pout4), 32'h5);
      cyc4(1'b1, 2'b01, 1'b0, 1'b1, 4'h0);
      chk("mid_sh2", 32'(pout4), 32'h2);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_pout4", 32'(pout4), 32'hA);
      chk("async_rst_wd4", 32'(wd4), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      en4 = 1'b0;

      // 2: 4-bit shift right of 1,0,1,1
      for (int i = 0; i < 4; i++) begin
         cyc4(1'b1, 2'b01, s2[i], 1'b0, 4'hF);
         chk("shr4_pout", 32'(pout4), 32'(p2[i]));
         chk("shr4_wd", 32'(wd4), (i == 3) ? 32'h1 : 32'h0);
      end
      chk("shr4_sout_r", 32'(sout_r4), 32'h1);
      cyc4(1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
      chk("shr4_wd_one_cycle", 32'(wd4), 32'h0);
      chk("shr4_en0_hold", 32'(pout4), 32'hD);

      // 3: PISO of A5, LSB first
      cyc8(1'b1, 2'b11, 1'b1, 1'b1, 8'hA5);
      chk("piso_load", 32'(pout8), 32'hA5);
      chk("piso_load_wd", 32'(wd8), 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk("piso_sout_r", 32'(sout_r8), 32'(a5[i]));
         cyc8(1'b1, 2'b01, 1'b0, 1'b1, 8'hFF);
         chk("piso_wd", 32'(wd8), (i == 7) ? 32'h1 : 32'h0);
      end
      chk("piso_empty", 32'(pout8), 32'h00);

      // 4: SIPO shift left of 3C, MSB first
      for (int i = 7; i >= 0; i--) begin
         cyc8(1'b1, 2'b10, 1'b1, s4[i], 8'hFF);
         chk("shl8_wd", 32'(wd8), (i == 0) ? 32'h1 : 32'h0);
      end
      chk("shl8_pout", 32'(pout8), 32'h3C);
      chk("shl8_sout_l", 32'(sout_l8), 32'h0);

      // 5a: stalls and a hold inside a right-shift word
      for (int i = 0; i < 3; i++) begin
         cyc8(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
         chk("stall_pre_wd", 32'(wd8), 32'h0);
      end
      chk("stall_pre_pout", 32'(pout8), 32'hE7);
      for (int i = 0; i < 2; i++) begin
         cyc8(1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
         chk("stall_en0_wd", 32'(wd8), 32'h0);
         chk("stall_en0_pout", 32'(pout8), 32'hE7);
      end
      cyc8(1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
      chk("stall_hold_wd", 32'(wd8), 32'h0);
      chk("stall_hold_pout", 32'(pout8), 32'hE7);
      for (int i = 0; i < 5; i++) begin
         cyc8(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
         chk("stall_post_wd", 32'(wd8), (i == 4) ? 32'h1 : 32'h0);
      end
      chk("stall_pout", 32'(pout8), 32'hFF);

      // 5b: direction change restarts the word count at 1
      for (int i = 0; i < 3; i++) begin
         cyc8(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
         chk("dir_r_wd", 32'(wd8), 32'h0);
      end
      chk("dir_r_pout", 32'(pout8), 32'h1F);
      cyc8(1'b1, 2'b10, 1'b1, 1'b0, 8'h00);
      chk("dir_first_l_wd", 32'(wd8), 32'h0);
      chk("dir_first_l_pout", 32'(pout8), 32'h3E);
      for (int i = 0; i < 7; i++) begin
         cyc8(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
         chk("dir_l_wd", 32'(wd8), (i == 6) ? 32'h1 : 32'h0);
      end
      chk("dir_l_pout", 32'(pout8), 32'h7F);

      // 6: load aborts a partial word
      for (int i = 0; i < 5; i++) begin
         cyc8(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
         chk("abort_pre_wd", 32'(wd8), 32'h0);
      end
      cyc8(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
      chk("abort_load_wd", 32'(wd8), 32'h0);
      chk("abort_load_pout", 32'(pout8), 32'hFF);
      for (int i = 0; i < 8; i++) begin
         cyc8(1'b1, 2'b01, s6[i], 1'b1, 8'h00);
         chk("abort_post_wd", 32'(wd8), (i == 7) ? 32'h1 : 32'h0);
      end
      chk("abort_pout", 32'(pout8), 32'h96);
      cyc8(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
      chk("abort_wd_clear", 32'(wd8), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
